// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch (I) and load/store (D); D wins ties except after MAX_D_STREAK back-to-back D grants with I waiting.
// Grant -> mem_req_o next cycle, done pulse on the cycle after mem_ready_i, then one DONE cycle before re-arbitration (3 cycles minimum).
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  i_req_i,
  input  logic [ADDR_WIDTH-1:0] i_addr_i,
  output logic [DATA_WIDTH-1:0] i_rdata_o,
  output logic                  i_done_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  input  logic [2:0]            d_funct3_i,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  output logic                  d_done_o,
  output logic                  stall_f_o,
  output logic                  stall_m_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [2:0]            mem_funct3_o,
  input  logic                  mem_ready_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int StreakW = $clog2(MAX_D_STREAK + 1);
  localparam logic [StreakW-1:0] MaxStreak = StreakW'(MAX_D_STREAK);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  state_t             state;
  logic [StreakW-1:0] streak;
  logic               grantD;

  // D wins unless I has been passed over MAX_D_STREAK times in a row.
  assign grantD = d_req_i && (!i_req_i || (streak < MaxStreak));

  assign stall_f_o = i_req_i & ~i_done_o;
  assign stall_m_o = d_req_i & ~d_done_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      streak       <= '0;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      mem_funct3_o <= 3'b000;
      i_done_o     <= 1'b0;
      d_done_o     <= 1'b0;
      i_rdata_o    <= '0;
      d_rdata_o    <= '0;
    end else begin
      i_done_o <= 1'b0;
      d_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (grantD) begin
            state        <= BUSY_D;
            streak       <= i_req_i ? streak + StreakW'(1) : '0;
            mem_req_o    <= 1'b1;
            mem_we_o     <= d_we_i;
            mem_addr_o   <= d_addr_i;
            mem_wdata_o  <= d_wdata_i;
            mem_funct3_o <= d_funct3_i;
          end else if (i_req_i) begin
            state        <= BUSY_I;
            streak       <= '0;
            mem_req_o    <= 1'b1;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= i_addr_i;
            mem_wdata_o  <= '0;
            mem_funct3_o <= 3'b010;
          end
        end
        BUSY_I: begin
          if (mem_ready_i) begin
            state     <= DONE;
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            i_done_o  <= 1'b1;
            i_rdata_o <= mem_rdata_i;
          end
        end
        BUSY_D: begin
          if (mem_ready_i) begin
            state     <= DONE;
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            d_done_o  <= 1'b1;
            // mem_we_o still reflects the granted access on this edge.
            if (!mem_we_o) d_rdata_o <= mem_rdata_i;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: handshake latency, stability, streak fairness, reset abort, load data retention.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        iReq, dReq, dWe, memReady;
  logic [31:0] iAddr, dAddr, dWdata, memRdata;
  logic [2:0]  dFunct3;
  logic [31:0] iRdata, dRdata, memAddr, memWdata;
  logic        iDone, dDone, stallF, stallM, memReq, memWe;
  logic [2:0]  memFunct3;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .i_req_i(iReq), .i_addr_i(iAddr), .i_rdata_o(iRdata), .i_done_o(iDone),
    .d_req_i(dReq), .d_we_i(dWe), .d_addr_i(dAddr), .d_wdata_i(dWdata),
    .d_funct3_i(dFunct3), .d_rdata_o(dRdata), .d_done_o(dDone),
    .stall_f_o(stallF), .stall_m_o(stallM),
    .mem_req_o(memReq), .mem_we_o(memWe), .mem_addr_o(memAddr),
    .mem_wdata_o(memWdata), .mem_funct3_o(memFunct3),
    .mem_ready_i(memReady), .mem_rdata_i(memRdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic waitDone(input string tag, output logic gotI, output logic gotD);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!iDone && !dDone && n < 10);
    check({tag, "_bound"}, 64'(iDone | dDone), 64'd1);
    gotI = iDone;
    gotD = dDone;
  endtask

  logic       gotI, gotD;
  logic       order[10];
  logic       expOrder[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  int         nDone, overlap;

  initial begin
    rst = 1'b1; iReq = 0; dReq = 0; dWe = 0; memReady = 0;
    iAddr = 0; dAddr = 0; dWdata = 0; memRdata = 0; dFunct3 = 0;
    tick(); tick();
    check("rst_mem_req", 64'(memReq), 0);
    check("rst_dones", 64'({iDone, dDone}), 0);
    check("rst_addr", 64'(memAddr), 0);
    check("rst_funct3", 64'(memFunct3), 0);
    check("rst_rdata", 64'({iRdata, dRdata}), 0);
    rst = 1'b0;
    tick();

    // Single fetch, memory ready immediately
    iReq = 1; iAddr = 32'h0; memReady = 1; memRdata = 32'h00500093;
    #1;
    check("f_stall_c0", 64'(stallF), 1);
    tick();
    check("f_req_c1", 64'({memReq, memWe, memFunct3}), 64'b1_0_010);
    check("f_stall_c1", 64'(stallF), 1);
    check("f_done_c1", 64'(iDone), 0);
    tick();
    check("f_done_c2", 64'(iDone), 1);
    check("f_rdata_c2", 64'(iRdata), 64'h00500093);
    check("f_stall_c2", 64'(stallF), 0);
    check("f_req_c2", 64'(memReq), 0);
    iReq = 0;
    tick();
    check("f_done_c3", 64'(iDone), 0);

    // Store with ready delayed; requester inputs change under it
    dReq = 1; dWe = 1; dAddr = 32'h100; dWdata = 32'hDEADBEEF; dFunct3 = 3'b000; memReady = 0;
    tick();
    dAddr = 32'h999; dWdata = 32'h0; dWe = 0; dFunct3 = 3'b111;
    for (int c = 0; c < 4; c++) begin
      check("st_addr", 64'(memAddr), 64'h100);
      check("st_wdata", 64'(memWdata), 64'hDEADBEEF);
      check("st_we_req", 64'({memReq, memWe, memFunct3}), 64'b1_1_000);
      check("st_no_done", 64'(dDone), 0);
      if (c == 3) begin
        memReady = 1;
        memRdata = 32'h12345678;
      end
      tick();
    end
    check("st_done", 64'(dDone), 1);
    check("st_rdata_kept", 64'(dRdata), 0);
    check("st_req_drop", 64'({memReq, memWe}), 0);
    dReq = 0;
    tick();
    check("st_single_pulse", 64'(dDone), 0);

    // Both held high: streak fairness
    iReq = 1; dReq = 1; dWe = 0; iAddr = 32'h80; dAddr = 32'h180; dFunct3 = 3'b010;
    memRdata = 32'hA5A5A5A5;
    nDone = 0; overlap = 0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (iDone || dDone) begin
        if (nDone < 10) order[nDone] = dDone;
        nDone++;
      end
      if (iDone && dDone) overlap++;
    end
    check("streak_count", 64'(nDone), 10);
    for (int j = 0; j < 10; j++) check($sformatf("streak_order%0d", j), 64'(order[j]), 64'(expOrder[j]));
    check("streak_overlap", 64'(overlap), 0);
    iReq = 0; dReq = 0;
    tick();

    // Simultaneous with streak 0: D then I
    iReq = 1; dReq = 1;
    waitDone("sim_first", gotI, gotD);
    check("sim_first_dI", 64'({gotD, gotI}), 64'b10);
    dReq = 0;
    waitDone("sim_second", gotI, gotD);
    check("sim_second_dI", 64'({gotD, gotI}), 64'b01);
    iReq = 0;
    tick();

    // Reset in the middle of a D access
    dReq = 1; dWe = 0; dAddr = 32'h300; memReady = 0;
    tick();
    check("rb_busy_req", 64'(memReq), 1);
    tick();
    rst = 1;
    tick();
    check("rb_req_drop", 64'(memReq), 0);
    check("rb_no_done", 64'({iDone, dDone}), 0);
    check("rb_rdata_clr", 64'({iRdata, dRdata}), 0);
    rst = 0; dReq = 0;
    tick();
    check("rb_idle_no_done", 64'(dDone), 0);
    dReq = 1; dAddr = 32'h400; memReady = 1; memRdata = 32'hCAFE0001;
    tick();
    check("rb_new_addr", 64'({memReq, memAddr}), {31'd0, 1'b1, 32'h400});
    tick();
    check("rb_new_done", 64'(dDone), 1);
    check("rb_new_rdata", 64'(dRdata), 64'hCAFE0001);
    dReq = 0;
    tick();

    // Load while I waits, then the I access leaves d_rdata alone
    iReq = 1; iAddr = 32'h40; dReq = 1; dWe = 0; dAddr = 32'h200; dFunct3 = 3'b100;
    memRdata = 32'h000000FF;
    tick();
    check("ld_addr", 64'({memAddr, memFunct3}), {29'd0, 32'h200, 3'b100});
    tick();
    check("ld_done", 64'({dDone, iDone}), 64'b10);
    check("ld_rdata", 64'(dRdata), 64'hFF);
    check("ld_stall_f", 64'(stallF), 1);
    dReq = 0; memRdata = 32'h11112222;
    tick();
    tick();
    check("ld_i_grant", 64'({memReq, memAddr, memFunct3}), {28'd0, 1'b1, 32'h40, 3'b010});
    tick();
    check("ld_i_done", 64'(iDone), 1);
    check("ld_i_rdata", 64'(iRdata), 64'h11112222);
    check("ld_d_kept", 64'(dRdata), 64'hFF);
    iReq = 0;
    tick();
    dReq = 1;
    #1;
    check("stall_m_idle", 64'(stallM), 1);
    dReq = 0;
    #1;
    check("stall_m_low", 64'(stallM), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
